// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, shared-ALU and response signals of the two-requester ALU arbiter
interface alu_arbiter_if #(
  parameter int WORDSIZE = 32
);
  logic                req0_valid;
  logic                req0_ready;
  logic [WORDSIZE-1:0] req0_in1;
  logic [WORDSIZE-1:0] req0_in2;
  logic [3:0]          req0_ctl;

  logic                req1_valid;
  logic                req1_ready;
  logic [WORDSIZE-1:0] req1_in1;
  logic [WORDSIZE-1:0] req1_in2;
  logic [3:0]          req1_ctl;

  logic [WORDSIZE-1:0] alu_in1;
  logic [WORDSIZE-1:0] alu_in2;
  logic [3:0]          alu_ctl;
  logic [WORDSIZE-1:0] alu_result;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [WORDSIZE-1:0] rsp_result;

  modport slave (
    input  req0_valid, req0_in1, req0_in2, req0_ctl,
    output req0_ready,
    input  req1_valid, req1_in1, req1_in2, req1_ctl,
    output req1_ready,
    output alu_in1, alu_in2, alu_ctl,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_result,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_in1, req0_in2, req0_ctl,
    input  req0_ready,
    output req1_valid, req1_in1, req1_in2, req1_ctl,
    input  req1_ready,
    input  alu_in1, alu_in2, alu_ctl,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_result,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - arbitrates two requesters onto one combinational ALU, registering one result.
// Define ALU_ARB_RR_EN for round-robin tie breaking; default is fixed priority to requester 0.
module alu_arbiter #(
  parameter int WORDSIZE = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state;
  logic [WORDSIZE-1:0] result_q;
  logic                id_q;
  logic                can_accept;
  logic                winner;
  logic                grant;

`ifdef ALU_ARB_RR_EN
  logic ptr;
  assign winner = (bus.req0_valid && bus.req1_valid) ? ptr : bus.req1_valid;
`else
  assign winner = bus.req1_valid && !bus.req0_valid;
`endif

  // A held result draining this cycle frees the slot for a same-cycle refill.
  assign can_accept = (state == EMPTY) || bus.rsp_ready;
  assign grant      = can_accept && (bus.req0_valid || bus.req1_valid);

  assign bus.req0_ready = grant && !winner;
  assign bus.req1_ready = grant && winner;

  assign bus.alu_in1 = winner ? bus.req1_in1 : bus.req0_in1;
  assign bus.alu_in2 = winner ? bus.req1_in2 : bus.req0_in2;
  assign bus.alu_ctl = winner ? bus.req1_ctl : bus.req0_ctl;

  assign bus.rsp_valid  = (state == FULL);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      result_q <= '0;
      id_q     <= 1'b0;
`ifdef ALU_ARB_RR_EN
      ptr      <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (grant) begin
            state    <= FULL;
            result_q <= bus.alu_result;
            id_q     <= winner;
`ifdef ALU_ARB_RR_EN
            ptr      <= ~winner;
`endif
          end
        end
        FULL: begin
          if (grant) begin
            result_q <= bus.alu_result;
            id_q     <= winner;
`ifdef ALU_ARB_RR_EN
            ptr      <= ~winner;
`endif
          end else if (bus.rsp_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with an external ALU model.
// Honours ALU_ARB_RR_EN the same way as the design.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  alu_arbiter_if #(.WORDSIZE(W)) bus ();

  alu_arbiter #(.WORDSIZE(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_XOR:  alu_f = a ^ b;
      default: alu_f = 32'hDEAD_BEEF ^ a;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_ctl, bus.alu_in1, bus.alu_in2);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: one result slot plus the tie-break owner.
  logic         m_valid = 1'b0;
  logic         m_id = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_ptr = 1'b0;
  logic         n_load = 1'b0;
  logic         n_id = 1'b0;
  logic [W-1:0] n_res = '0;
  logic         n_drain = 1'b0;
  logic         e_acc, e_w, e_any;
  logic [3:0]   e_ctl;
  logic [W-1:0] e_in1, e_in2;

  always @(negedge clk) begin
    if (mon_en) begin
      e_acc = !m_valid || bus.rsp_ready;
      e_any = bus.req0_valid || bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_RR_EN
        e_w = m_ptr;
`else
        e_w = 1'b0;
`endif
      end else begin
        e_w = bus.req1_valid;
      end
      e_ctl = e_w ? bus.req1_ctl : bus.req0_ctl;
      e_in1 = e_w ? bus.req1_in1 : bus.req0_in1;
      e_in2 = e_w ? bus.req1_in2 : bus.req0_in2;
      chk("mon_req0_ready", W'(bus.req0_ready), W'(e_acc && e_any && !e_w));
      chk("mon_req1_ready", W'(bus.req1_ready), W'(e_acc && e_any && e_w));
      chk("mon_alu_ctl", W'(bus.alu_ctl), W'(e_ctl));
      chk("mon_alu_in1", bus.alu_in1, e_in1);
      chk("mon_alu_in2", bus.alu_in2, e_in2);
      chk("mon_rsp_valid", W'(bus.rsp_valid), W'(m_valid));
      if (m_valid) begin
        chk("mon_rsp_id", W'(bus.rsp_id), W'(m_id));
        chk("mon_rsp_result", bus.rsp_result, m_res);
      end
      n_load  = e_acc && e_any;
      n_id    = e_w;
      n_res   = alu_f(e_ctl, e_in1, e_in2);
      n_drain = bus.rsp_ready;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_id    = 1'b0;
      m_res   = '0;
      m_ptr   = 1'b0;
    end else if (n_load) begin
      m_valid = 1'b1;
      m_id    = n_id;
      m_res   = n_res;
      m_ptr   = ~n_id;
    end else if (n_drain) begin
      m_valid = 1'b0;
    end
    n_load = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (k == 0) begin
      bus.req0_valid = v; bus.req0_ctl = op; bus.req0_in1 = a; bus.req0_in2 = b;
    end else begin
      bus.req1_valid = v; bus.req1_ctl = op; bus.req1_in1 = a; bus.req1_in2 = b;
    end
  endtask

  initial begin
    drive(0, 1'b0, OP_ADD, '0, '0);
    drive(1, 1'b0, OP_ADD, '0, '0);
    bus.rsp_ready = 1'b1;
    mon_en = 1'b1;
    #2;
    chk("reset_rsp_valid", W'(bus.rsp_valid), '0);
    chk("reset_rsp_id", W'(bus.rsp_id), '0);
    chk("reset_rsp_result", bus.rsp_result, '0);
    tick();
    rst_n = 1'b1;

    // Single op
    drive(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    #1 chk("single_req0_ready", W'(bus.req0_ready), 1);
    tick();
    drive(0, 1'b0, OP_ADD, 32'd5, 32'd7);
    #1;
    chk("single_rsp_valid", W'(bus.rsp_valid), 1);
    chk("single_rsp_id", W'(bus.rsp_id), 0);
    chk("single_rsp_result", bus.rsp_result, 32'd12);

    // Backpressure with requester-0 fields wandering while not granted
    drive(1, 1'b1, OP_SUB, 32'd10, 32'd3);
    #1 chk("bp_req1_ready", W'(bus.req1_ready), 1);
    tick();
    drive(1, 1'b0, OP_SUB, 32'd10, 32'd3);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, OP_OR, 32'd99 + W'(i), 32'd1);
      #1;
      chk("bp_rsp_result", bus.rsp_result, 32'd7);
      chk("bp_rsp_id", W'(bus.rsp_id), 1);
      chk("bp_req0_ready", W'(bus.req0_ready), 0);
      tick();
    end
    drive(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    bus.rsp_ready = 1'b1;
    #1 chk("bp_release_req0_ready", W'(bus.req0_ready), 1);
    tick();
    drive(0, 1'b0, OP_ADD, '0, '0);
    #1;
    chk("bp_next_result", bus.rsp_result, 32'd12);
    chk("bp_next_id", W'(bus.rsp_id), 0);
    tick();
    chk("drain_rsp_valid", W'(bus.rsp_valid), 0);

    // Tie, starting from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    drive(1, 1'b1, OP_ADD, 32'd2, 32'd2);
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef ALU_ARB_RR_EN
      chk("tie_req0_ready", W'(bus.req0_ready), W'(i % 2 == 0));
      chk("tie_req1_ready", W'(bus.req1_ready), W'(i % 2 == 1));
`else
      chk("tie_req0_ready", W'(bus.req0_ready), 1);
      chk("tie_req1_ready", W'(bus.req1_ready), 0);
`endif
      tick();
`ifdef ALU_ARB_RR_EN
      chk("tie_rsp_id", W'(bus.rsp_id), W'(i % 2));
      chk("tie_rsp_result", bus.rsp_result, (i % 2 == 0) ? 32'd2 : 32'd4);
`else
      chk("tie_rsp_id", W'(bus.rsp_id), 0);
      chk("tie_rsp_result", bus.rsp_result, 32'd2);
`endif
    end
    drive(0, 1'b0, OP_ADD, '0, '0);
    drive(1, 1'b0, OP_ADD, '0, '0);
    tick();

    // Asynchronous reset while holding a result
    drive(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    tick();
    drive(0, 1'b0, OP_ADD, '0, '0);
    bus.rsp_ready = 1'b0;
    #1 chk("areset_pre_result", bus.rsp_result, 32'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_rsp_valid", W'(bus.rsp_valid), 0);
    chk("areset_rsp_result", bus.rsp_result, 0);
    chk("areset_rsp_id", W'(bus.rsp_id), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("areset_no_stale", W'(bus.rsp_valid), 0);
    bus.rsp_ready = 1'b1;

    // Back-to-back from one requester
    drive(0, 1'b1, OP_XOR, 32'hF0, 32'h0F);
    tick();
    drive(0, 1'b1, OP_AND, 32'hFF, 32'h0F);
    #1 chk("b2b_first", bus.rsp_result, 32'hFF);
    tick();
    drive(0, 1'b0, OP_ADD, '0, '0);
    #1;
    chk("b2b_second", bus.rsp_result, 32'h0F);
    chk("b2b_valid", W'(bus.rsp_valid), 1);

    // Illegal opcode passes straight through
    drive(1, 1'b1, 4'hF, 32'd3, 32'd0);
    #1 chk("illegal_alu_ctl", W'(bus.alu_ctl), 32'hF);
    tick();
    drive(1, 1'b0, OP_ADD, '0, '0);
    #1 chk("illegal_result", bus.rsp_result, 32'hDEAD_BEEC);
    tick();
    tick();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
